// File: rtl/st7920_pkg.sv
// Shared types and command constants for the ST7920 refresh scheduler.
// Init ROM entry 0 is issued first.
package st7920_pkg;

   typedef enum logic [3:0] {
      IDLE,
      INIT,
      ROW_Y,
      ROW_X,
      FETCH,
      WAIT_RD,
      SEND,
      GAP,
      DONE
   } sched_state_t;

   typedef struct packed {
      logic       rs;
      logic       rw;
      logic [7:0] data;
   } lcd_cmd_t;

   localparam logic [7:0] CMD_BASIC_8BIT = 8'h30;
   localparam logic [7:0] CMD_DISP_ON    = 8'h0C;
   localparam logic [7:0] CMD_EXT        = 8'h34;
   localparam logic [7:0] CMD_GFX_ON     = 8'h36;
   localparam logic [7:0] CMD_SET_ADDR   = 8'h80;

   localparam logic [3:0][7:0] INIT_ROM = {
      CMD_GFX_ON, CMD_EXT, CMD_DISP_ON, CMD_BASIC_8BIT
   };

endpackage

// File: rtl/st7920_gap_timer.sv
// Post-command settle timer: load on acceptance, count down to zero.
// expired is high whenever the count has reached zero.
module st7920_gap_timer #(
   parameter int GAP_CYCLES = 3600
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic load,
   output logic expired
);

   localparam int CW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam logic [CW-1:0] LOAD_VAL = CW'(GAP_CYCLES);

   logic [CW-1:0] cnt;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= LOAD_VAL;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/st7920_refresh_scheduler.sv
// Full-screen refresh sequencer for a 128x64 ST7920 in extended graphic mode.
// Walks init list, then per row set-Y, set-X and 32 framebuffer bytes.
module st7920_refresh_scheduler
   import st7920_pkg::*;
#(
   parameter int GAP_CYCLES = 3600,
   parameter int ROWS       = 32,
   parameter int FB_AW      = 10
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             frame_req,
   output logic             busy,
   output logic             frame_done,
   output logic             fb_rd_en,
   output logic [FB_AW-1:0] fb_rd_addr,
   input  logic [7:0]       fb_rd_data,
   output logic             cmd_valid,
   output logic             cmd_rs,
   output logic             cmd_rw,
   output logic [7:0]       cmd_data,
   input  logic             cmd_ready
);

   sched_state_t state, state_n, from_st;
   lcd_cmd_t     cmd;
   logic         init_done, pending, start, accept, expired;
   logic [1:0]   idx;
   logic [4:0]   row, k;
   logic [7:0]   rd_data;
   logic         last_row, last_k;

   assign start    = frame_req | pending;
   assign accept   = cmd_valid & cmd_ready;
   assign last_row = (row == 5'(ROWS - 1));
   assign last_k   = (k == 5'd31);

   st7920_gap_timer #(
      .GAP_CYCLES(GAP_CYCLES)
   ) u_gap (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .load     (accept),
      .expired  (expired)
   );

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= IDLE;
         from_st   <= IDLE;
         init_done <= 1'b0;
         pending   <= 1'b0;
         idx       <= '0;
         row       <= '0;
         k         <= '0;
         rd_data   <= '0;
      end else begin
         state <= state_n;
         if (state == IDLE) begin
            if (start) begin
               pending <= 1'b0;
               idx     <= '0;
               row     <= '0;
               k       <= '0;
            end
         end else if (frame_req) begin
            pending <= 1'b1;
         end
         if (accept) begin
            from_st <= state;
            if (state == INIT) begin
               if (idx == 2'd3) init_done <= 1'b1;
               else             idx       <= idx + 2'd1;
            end
         end
         if (state == WAIT_RD) rd_data <= fb_rd_data;
         // byte/row counters advance only when leaving a data gap
         if (state == GAP && expired && from_st == SEND) begin
            if (last_k) begin
               k <= '0;
               if (!last_row) row <= row + 5'd1;
            end else begin
               k <= k + 5'd1;
            end
         end
      end
   end

   always_comb begin
      state_n    = state;
      cmd        = '0;
      cmd_valid  = 1'b0;
      fb_rd_en   = 1'b0;
      fb_rd_addr = '0;
      frame_done = 1'b0;
      busy       = (state != IDLE);
      unique case (state)
         IDLE: begin
            if (start) state_n = init_done ? ROW_Y : INIT;
         end
         INIT: begin
            cmd_valid = 1'b1;
            cmd.data  = INIT_ROM[idx];
            if (cmd_ready) state_n = GAP;
         end
         ROW_Y: begin
            cmd_valid = 1'b1;
            cmd.data  = CMD_SET_ADDR | {3'b000, row};
            if (cmd_ready) state_n = GAP;
         end
         ROW_X: begin
            cmd_valid = 1'b1;
            cmd.data  = CMD_SET_ADDR;
            if (cmd_ready) state_n = GAP;
         end
         FETCH: begin
            fb_rd_en   = 1'b1;
            fb_rd_addr = FB_AW'({k[4], row, k[3:0]});
            state_n    = WAIT_RD;
         end
         WAIT_RD: begin
            state_n = SEND;
         end
         SEND: begin
            cmd_valid = 1'b1;
            cmd.rs    = 1'b1;
            cmd.data  = rd_data;
            if (cmd_ready) state_n = GAP;
         end
         GAP: begin
            if (expired) begin
               unique case (from_st)
                  INIT:    state_n = init_done ? ROW_Y : INIT;
                  ROW_Y:   state_n = ROW_X;
                  ROW_X:   state_n = FETCH;
                  SEND:    state_n = !last_k   ? FETCH :
                                     last_row  ? DONE  : ROW_Y;
                  default: state_n = IDLE;
               endcase
            end
         end
         DONE: begin
            frame_done = 1'b1;
            state_n    = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign cmd_rs   = cmd.rs;
   assign cmd_rw   = cmd.rw;
   assign cmd_data = cmd.data;

endmodule
